// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/data request ports and shared memory port of mem_port_arbiter.
// slave is the arbiter side, master the pipeline/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              if_stall;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              d_stall;
   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             m_en, m_we, m_addr, m_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             m_en, m_we, m_addr, m_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-IF priority.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

   state_t            state_q;
   logic              owner_q;
   logic              we_q;
   logic [3:0]        cnt_q;
   logic              m_en_q;
   logic              m_we_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_ready_q;
   logic              d_ready_q;
   logic              if_v;
   logic              d_v;
   logic              grant;
   logic              pick_d;

   // owner_q = 1 means the data port; its request is masked during its own DONE
   assign if_v  = bus.if_req & ~(state_q == DONE & ~owner_q);
   assign d_v   = bus.d_req & ~(state_q == DONE & owner_q);
   assign grant = (state_q == IDLE | state_q == DONE) & (if_v | d_v);

`ifdef MEM_ARB_RR_EN
   logic last_d_q;
   assign pick_d = d_v & (~if_v | ~last_d_q);
`else
   assign pick_d = d_v;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         cnt_q      <= 4'd0;
         m_en_q     <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d_q   <= 1'b0;
`endif
      end else begin
         m_en_q     <= 1'b0;
         m_we_q     <= 1'b0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         case (state_q)
            IDLE, DONE:
               if (grant) begin
                  state_q  <= CMD;
                  owner_q  <= pick_d;
                  we_q     <= pick_d & bus.d_we;
                  m_en_q   <= 1'b1;
                  m_we_q   <= pick_d & bus.d_we;
                  m_addr_q <= pick_d ? bus.d_addr : bus.if_addr;
                  if (pick_d) m_wdata_q <= bus.d_wdata;
`ifdef MEM_ARB_RR_EN
                  last_d_q <= pick_d;
`endif
               end else begin
                  state_q <= IDLE;
               end
            CMD: begin
               cnt_q   <= 4'(MEM_LAT);
               state_q <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= DONE;
                  if (!we_q && owner_q) d_rdata_q <= bus.m_rdata;
                  if (!we_q && !owner_q) if_rdata_q <= bus.m_rdata;
                  d_ready_q  <= owner_q;
                  if_ready_q <= ~owner_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end

   assign bus.m_en     = m_en_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.if_ready = if_ready_q;
   assign bus.d_ready  = d_ready_q;
   assign bus.if_stall = bus.if_req & ~if_ready_q;
   assign bus.d_stall  = bus.d_req & ~d_ready_q;
   assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at MEM_LAT=2 and MEM_LAT=15.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b15 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst), .bus(b.slave)
   );
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut15 (
      .clk(clk), .rst(rst), .bus(b15.slave)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
   endfunction

   // read data is valid only in the cycle MEM_LAT after the command, junk otherwise
   logic [31:0] p2 [0:1];
   logic [31:0] p15 [0:14];
   always @(posedge clk) begin
      p2[0] <= (b.m_en & ~b.m_we) ? memf(b.m_addr) : 32'hBAD0BAD0;
      p2[1] <= p2[0];
      p15[0] <= (b15.m_en & ~b15.m_we) ? memf(b15.m_addr) : 32'hBAD0BAD0;
      for (int i = 1; i < 15; i++) p15[i] <= p15[i-1];
   end
   assign b.m_rdata   = p2[1];
   assign b15.m_rdata = p15[14];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic single_if(input string t, input logic [31:0] a, input logic [31:0] exp);
      b.if_addr = a;
      b.if_req  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk({t, "_m_en"}, 32'(b.m_en), 32'(c == 1));
         chk({t, "_if_ready"}, 32'(b.if_ready), 32'(c == 4));
         chk({t, "_if_stall"}, 32'(b.if_stall), 32'(c < 4));
         chk({t, "_busy"}, 32'(b.busy), 32'(c >= 1 && c <= 4));
         if (c == 1) chk({t, "_m_addr"}, b.m_addr, a);
         if (c == 4) chk({t, "_if_rdata"}, b.if_rdata, exp);
         @(posedge clk); #1;
         if (c == 4) b.if_req = 1'b0;
      end
   endtask

   task automatic pair(input string t, input bit first_d, input logic [31:0] da, input logic [31:0] ia);
      b.d_addr = da; b.d_we = 1'b0; b.d_req = 1'b1;
      b.if_addr = ia; b.if_req = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk({t, "_m_en"}, 32'(b.m_en), 32'(c == 1 || c == 5));
         chk({t, "_d_ready"}, 32'(b.d_ready), 32'(c == (first_d ? 4 : 8)));
         chk({t, "_if_ready"}, 32'(b.if_ready), 32'(c == (first_d ? 8 : 4)));
         if (c == 1) chk({t, "_addr1"}, b.m_addr, first_d ? da : ia);
         if (c == 5) chk({t, "_addr2"}, b.m_addr, first_d ? ia : da);
         if (b.d_ready) chk({t, "_d_rdata"}, b.d_rdata, memf(da));
         if (b.if_ready) chk({t, "_if_rdata"}, b.if_rdata, memf(ia));
         @(posedge clk); #1;
         if (b.d_ready) b.d_req = 1'b0;
         if (b.if_ready) b.if_req = 1'b0;
      end
      b.d_req = 1'b0; b.if_req = 1'b0;
   endtask

   initial begin
      b.if_req = 1'b0; b.if_addr = '0;
      b.d_req = 1'b0; b.d_we = 1'b0; b.d_addr = '0; b.d_wdata = '0;
      b15.if_req = 1'b0; b15.if_addr = '0;
      b15.d_req = 1'b0; b15.d_we = 1'b0; b15.d_addr = '0; b15.d_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_m_en", 32'(b.m_en), 32'd0);
      chk("rst_busy", 32'(b.busy), 32'd0);
      chk("rst_m_addr", b.m_addr, 32'd0);
      chk("rst_if_rdata", b.if_rdata, 32'd0);
      chk("rst_d_ready", 32'(b.d_ready), 32'd0);
      @(posedge clk); #1;

      single_if("rd", 32'h40, 32'hDEADBEEF);
      pair("pair", 1'b1, 32'h80, 32'h44);

      b.d_addr = 32'h100; b.d_wdata = 32'h12345678; b.d_we = 1'b1; b.d_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("wr_m_en", 32'(b.m_en), 32'(c == 1));
         chk("wr_m_we", 32'(b.m_we), 32'(c == 1));
         chk("wr_d_ready", 32'(b.d_ready), 32'(c == 4));
         chk("wr_d_stall", 32'(b.d_stall), 32'(c < 4));
         if (c == 1) chk("wr_m_addr", b.m_addr, 32'h100);
         if (c == 1) chk("wr_m_wdata", b.m_wdata, 32'h12345678);
         if (c == 4) chk("wr_d_rdata", b.d_rdata, 32'h5A5A0080);
         @(posedge clk); #1;
         if (c == 4) begin b.d_req = 1'b0; b.d_we = 1'b0; end
      end

`ifdef MEM_ARB_RR_EN
      pair("pair_after_d", 1'b0, 32'h84, 32'h48);
`else
      pair("pair_after_d", 1'b1, 32'h84, 32'h48);
`endif

      b.if_addr = 32'h60; b.if_req = 1'b1;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         chk("cont_m_en", 32'(b.m_en), 32'(c == 1 || c == 6));
         chk("cont_if_ready", 32'(b.if_ready), 32'(c == 4 || c == 9));
         @(posedge clk); #1;
         if (c == 9) b.if_req = 1'b0;
      end

      b.if_addr = 32'h40; b.if_req = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("arst_m_en", 32'(b.m_en), 32'd0);
      chk("arst_m_we", 32'(b.m_we), 32'd0);
      chk("arst_m_addr", b.m_addr, 32'd0);
      chk("arst_m_wdata", b.m_wdata, 32'd0);
      chk("arst_if_rdata", b.if_rdata, 32'd0);
      chk("arst_d_rdata", b.d_rdata, 32'd0);
      chk("arst_busy", 32'(b.busy), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("arst_if_ready", 32'(b.if_ready), 32'd0);
      end
      @(posedge clk); #1 rst = 1'b1;
      single_if("restart", 32'h40, 32'hDEADBEEF);

      b15.if_addr = 32'h2000; b15.if_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("lat15_m_en", 32'(b15.m_en), 32'(c == 1));
         chk("lat15_if_ready", 32'(b15.if_ready), 32'(c == 17));
         if (c == 17) chk("lat15_if_rdata", b15.if_rdata, 32'h5A5A2000);
         @(posedge clk); #1;
         if (c == 17) b15.if_req = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported, fixed-latency unified memory shared between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port. It grants one requester at a time, drives the memory port for exactly one command cycle, and waits out the memory latency. It then returns read data with a one-cycle ready pulse and exports per-port stall signals that feed the hazard logic alongside the existing PC/IF_ID write enables.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15; 0 is illegal
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset; one clock, no other clock domains
- if_req  input  1  instruction fetch request, held until if_ready
- if_addr  input  ADDR_W  fetch address, stable while if_req
- if_rdata  output  DATA_W  registered fetched word
- if_ready  output  1  one-cycle completion pulse for IF
- if_stall  output  1  if_req & ~if_ready (combinational)
- d_req  input  1  data access request, held until d_ready
- d_we  input  1  1 = write, 0 = read; stable while d_req
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_rdata  output  DATA_W  registered load data
- d_ready  output  1  one-cycle completion pulse for data port
- d_stall  output  1  d_req & ~d_ready (combinational)
- m_en  output  1  memory command strobe, high one cycle per access
- m_we  output  1  memory write enable, qualified by m_en
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after m_en cycle
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, CMD, WAIT, DONE.
- IDLE: if any unmasked request is present, pick a winner, latch its addr/we/wdata and grant owner, and go to CMD.
- CMD: m_en=1, m_we=latched we. Load the 4-bit counter with MEM_LAT, then go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, capture m_rdata into the owner's rdata register (reads only; writes leave rdata unchanged) and go to DONE.
- DONE: pulse the owner's ready. Mask the owner's request for this cycle only. A request from the other port present in DONE is arbitrated as if in IDLE, so the next state is CMD.
- Arbitration default: d_req wins over if_req (the MEM-stage instruction is older).
- m_addr/m_wdata hold the last issued value outside CMD; m_we=0 whenever m_en=0.
- Reset (rst low, any state, including mid-access): immediate return to IDLE. The in-flight access is abandoned and no ready is issued. All registered outputs go to 0: m_en, m_we, m_addr, m_wdata, if_rdata, d_rdata, if_ready, d_ready, busy. The round-robin pointer resets to "IF last", so data goes first.

## Timing
- Request sampled in cycle T → m_en in T+1 → m_rdata captured at end of T+1+MEM_LAT → ready in T+2+MEM_LAT.
- Throughput: back-to-back alternating ports complete one access every MEM_LAT+2 cycles.
- The same port re-requesting has at least one idle cycle, because its request is masked in DONE.
- A requester must keep req, addr, we and wdata stable until it samples ready. Changing them mid-access is undefined.
- Request arrival during CMD/WAIT is held pending and has no effect on the current access.

## Configuration
- MEM_ARB_RR_EN defined: round-robin between ports when both request in the same arbitration cycle; the port not granted last wins. A 1-bit last-grant register updates on each grant.
- MEM_ARB_RR_EN undefined: fixed data-over-IF priority; no last-grant register.

## Test plan
- Single read, MEM_LAT=2: if_req at cycle 0, addr 0x40, memory returns 0xDEADBEEF. Required: m_en only in cycle 1, if_ready only in cycle 4, if_rdata=0xDEADBEEF, if_stall high cycles 0–3.
- Write: d_req, d_we=1, d_addr 0x100, d_wdata 0x12345678. Required: m_en=m_we=1 in one cycle with those values, d_ready after MEM_LAT+2 cycles, d_rdata unchanged.
- Simultaneous if_req and d_req at cycle 0, fixed priority: data granted first with d_ready at cycle 4, IF command at cycle 5 and if_ready at cycle 8. With MEM_ARB_RR_EN, a repeated simultaneous pair alternates grants.
- IF held high continuously while the data port is idle: IF is granted once per 5 cycles (MEM_LAT=2), never re-granted in its own DONE cycle.
- rst asserted low during WAIT: all outputs 0 asynchronously, no ready pulse. After release, a pending request restarts from IDLE.
- MEM_LAT=15: ready arrives exactly 17 cycles after the request; counter wrap does not occur.
